l1_dcache: RTL
==============

L1_DCACHE -- requirements
Module: l1_dcache

Interface
REQ-001 Parameter s_index, default 4, meaning index bits; 2**s_index sets, direct-mapped.
REQ-002 Parameter s_offset, default 5, meaning byte-offset bits; 32-byte (256-bit) line.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 mem_read  input  1  CPU load request, held until mem_resp.
REQ-007 mem_write  input  1  CPU store request, held until mem_resp.
REQ-008 mem_byte_enable  input  4  store byte lanes.
REQ-009 mem_address  input  32  CPU byte address.
REQ-010 mem_wdata  input  32  store data.
REQ-011 mem_rdata  output  32  load data, valid when mem_resp=1.
REQ-012 mem_resp  output  1  one-cycle completion pulse.
REQ-013 pmem_read  output  1  line fill request, held until pmem_resp.
REQ-014 pmem_write  output  1  line writeback request, held until pmem_resp.
REQ-015 pmem_address  output  32  line-aligned address (low s_offset bits zero).
REQ-016 pmem_wdata  output  256  writeback line.
REQ-017 pmem_rdata  input  256  fill line, valid with pmem_resp.
REQ-018 pmem_resp  input  1  memory completion pulse.

Function
REQ-019 Address split: tag=[31:9], index=[8:5], word=[4:2]; bits [1:0] ignored.
REQ-020 Per set: valid bit, dirty bit, 23-bit tag, 256-bit data, all in flops with combinational read.
REQ-021 FSM states: CHECK, WRITEBACK, FILL; reset state CHECK.
REQ-022 CHECK, no request: all outputs 0 except mem_rdata (don't-care), stay CHECK.
REQ-023 CHECK, hit (valid && tag match): mem_resp=1 same cycle (zero-cycle hit latency), stay CHECK.
REQ-024 Read hit: mem_rdata = selected 32-bit word of the line, combinational.
REQ-025 Write hit: at the clock edge with mem_resp=1, bytes with byte_enable=1 overwritten, others unchanged; dirty set.
REQ-026 Miss, line invalid or clean: go FILL next cycle, mem_resp=0.
REQ-027 Miss, line valid and dirty: go WRITEBACK next cycle, mem_resp=0.
REQ-028 WRITEBACK: pmem_write=1, pmem_address={stored tag, index, 5'b0}, pmem_wdata=stored line; on pmem_resp clear dirty, go FILL.
REQ-029 FILL: pmem_read=1, pmem_address={mem_address[31:5], 5'b0}; on pmem_resp write pmem_rdata, set valid, clear dirty, write tag, go CHECK.
REQ-030 After FILL, request is serviced in CHECK as a hit; miss latency = memory latency + 1 cycle (clean) or + writeback latency (dirty).
REQ-031 pmem_read and pmem_write never both 1; each held constant until pmem_resp.
REQ-032 pmem_resp while in CHECK ignored.
REQ-033 mem_read and mem_write both 1: treated as write.
REQ-034 mem_resp never 1 outside CHECK.
REQ-035 Requests with changed address mid-miss are unsupported; requester holds inputs stable until mem_resp.

Reset
REQ-036 rst=0 asynchronously forces state CHECK, all valid and dirty bits 0, mem_resp=0, pmem_read=0, pmem_write=0.
REQ-037 Reset mid-WRITEBACK or mid-FILL abandons the transaction; no array update; later pmem_resp ignored.
REQ-038 Tag and data arrays need no reset value.

Verification
REQ-039 After reset, read 0x0000_0040; memory returns line with word0=0x1111_1111 after 3 cycles -> pmem_read held 3 cycles at 0x0000_0040, mem_resp next cycle with mem_rdata=0x1111_1111.
REQ-040 Write hit 0x0000_0044, byte_enable=4'b0011, wdata=0xAABB_CCDD over 0x2222_2222 -> mem_resp same cycle; subsequent read = 0x2222_CCDD, no pmem activity.
REQ-041 Read 0x0000_0240 (same index 2, different tag) while dirty -> pmem_write at 0x0000_0040 with modified line, then pmem_read at 0x0000_0240, then mem_resp.
REQ-042 Back-to-back hits to distinct words of one line -> mem_resp every cycle, zero pmem traffic.
REQ-043 rst asserted two cycles into FILL -> pmem_read drops immediately; read of same address afterwards misses again.
REQ-044 mem_read=mem_write=1 on a hit -> store applied, mem_resp=1, dirty set.

Source files
------------

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-back L1 data cache with zero-cycle hits
module l1_dcache #(
    parameter int s_index  = 4,
    parameter int s_offset = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [3:0]                 mem_byte_enable,
    input  logic [31:0]                mem_address,
    input  logic [31:0]                mem_wdata,
    output logic [31:0]                mem_rdata,
    output logic                       mem_resp,
    output logic                       pmem_read,
    output logic                       pmem_write,
    output logic [31:0]                pmem_address,
    output logic [(8<<s_offset)-1:0]   pmem_wdata,
    input  logic [(8<<s_offset)-1:0]   pmem_rdata,
    input  logic                       pmem_resp
);
    localparam int sets   = 1 << s_index;
    localparam int tag_w  = 32 - s_index - s_offset;
    localparam int word_w = s_offset - 2;
    localparam int line_w = 8 << s_offset;

    typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_e;

    state_e                  state_q, state_d;
    logic [sets-1:0]         valid_q, valid_d;
    logic [sets-1:0]         dirty_q, dirty_d;
    logic [tag_w-1:0]        tag_q [sets];
    logic [line_w-1:0]       data_q [sets];

    logic [tag_w-1:0]        tag;
    logic [s_index-1:0]      idx;
    logic [word_w-1:0]       word;
    logic                    req;
    logic                    hit;
    logic                    fill_we;
    logic                    store_we;
    logic [line_w-1:0]       line_cur;
    logic [line_w-1:0]       store_line;
    logic                    unused;

    assign tag      = mem_address[31 -: tag_w];
    assign idx      = mem_address[s_offset +: s_index];
    assign word     = mem_address[2 +: word_w];
    assign unused   = &{1'b0, mem_address[1:0]};
    assign req      = mem_read | mem_write;
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign line_cur = data_q[idx];
    assign mem_rdata = line_cur[32*word +: 32];

    // Merge the enabled store bytes into the selected word of the resident line.
    always_comb begin
        store_line = line_cur;
        for (int b = 0; b < 4; b++)
            if (mem_byte_enable[b])
                store_line[32*word + 8*b +: 8] = mem_wdata[8*b +: 8];
    end

    // Next state, handshake outputs and valid/dirty updates; everything idles at zero.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        fill_we      = 1'b0;
        store_we     = 1'b0;
        case (state_q)
            CHECK: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    store_we = mem_write;
                    dirty_d[idx] = dirty_q[idx] | mem_write;
                end else if (req) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx], idx, {s_offset{1'b0}}};
                pmem_wdata   = line_cur;
                if (pmem_resp) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
                if (pmem_resp) begin
                    fill_we      = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = CHECK;
                end
            end
            default: state_d = CHECK;
        endcase
    end

    // State and per-set status bits; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CHECK;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays: loaded on fill completion or merged on a store hit.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= pmem_rdata;
        end else if (store_we) begin
            data_q[idx] <= store_line;
        end
    end
endmodule
